// File: rtl/ram_read_arbiter.sv
// ram_read_arbiter: round-robin arbiter sharing one MIG read path among NUM_REQ clients, 2-beat bursts with watchdog.
module ram_read_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 27,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ-1:0]        rsp_err,
  output logic [127:0]              rsp_data,
  output logic [ADDR_W-1:0]         ram_address,
  output logic [2:0]                ram_cmd,
  output logic                      ram_en,
  input  logic                      ram_rdy,
  input  logic                      ram_rd_valid,
  input  logic                      ram_rd_data_end,
  input  logic [63:0]               ram_rd_data,
  output logic                      busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DATA0, DATA1} state_t;
  state_t state, state_n;
  logic [IW-1:0] rr, gnt, win;
  logic [IW:0] idx;
  logic found, done_ok, done_err, time_up, grant;
  logic [TW-1:0] timer;
  always_comb begin
    found = 1'b0;
    win = rr;
    idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, rr} + (IW+1)'(k);
      idx = (idx >= (IW+1)'(NUM_REQ)) ? idx - (IW+1)'(NUM_REQ) : idx;
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        win = idx[IW-1:0];
      end
    end
  end
  assign grant = state == IDLE && found;
  assign time_up = timer >= TW'(TIMEOUT_CYC - 1);
  always_comb begin
    state_n = state;
    done_ok = 1'b0;
    done_err = 1'b0;
    case (state)
      IDLE:    state_n = found ? ISSUE : IDLE;
      ISSUE:   state_n = ram_rdy ? DATA0 : ISSUE;
      DATA0: begin
        done_err = (ram_rd_valid && ram_rd_data_end) || (!ram_rd_valid && time_up);
        state_n = ram_rd_valid ? DATA1 : DATA0;
      end
      DATA1: begin
        done_ok = ram_rd_valid && ram_rd_data_end;
        done_err = !done_ok && time_up;
      end
      default: state_n = IDLE;
    endcase
    state_n = (done_ok || done_err) ? IDLE : state_n;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr <= '0;
      gnt <= '0;
      timer <= '0;
      rsp_data <= '0;
      ram_address <= '0;
      rsp_valid <= '0;
      rsp_err <= '0;
    end else begin
      rsp_valid <= done_ok ? NUM_REQ'(1) << gnt : '0;
      rsp_err <= done_err ? NUM_REQ'(1) << gnt : '0;
      timer <= (state == DATA0 || state == DATA1) ? timer + 1'b1 : '0;
      if (grant) begin
        gnt <= win;
        ram_address <= req_addr[win*ADDR_W +: ADDR_W] & ~ADDR_W'(7);
      end
      if (done_ok || done_err) rr <= gnt;
      if (state == DATA0 && ram_rd_valid && !ram_rd_data_end) rsp_data[63:0] <= ram_rd_data;
      if (done_ok) rsp_data[127:64] <= ram_rd_data;
    end
  end
  assign req_ack = grant ? NUM_REQ'(1) << win : '0;
  assign ram_en = state == ISSUE;
  assign ram_cmd = (state == ISSUE) ? 3'b001 : 3'b000;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_ram_read_arbiter.sv
// tb_ram_read_arbiter: directed checks of a 2-client and a 3-client arbiter sharing one MIG model.
module tb_ram_read_arbiter;
  localparam int AW = 27;
  logic clk = 1'b0, reset_n = 1'b0;
  logic rdy = 1'b0, rv = 1'b0, rend = 1'b0;
  logic [63:0] rdata = '0;
  logic [1:0] req2 = '0, ack2, v2, e2;
  logic [2*AW-1:0] addr2 = {27'h0ABCDEF, 27'h1234567};
  logic [127:0] data2, data3;
  logic [AW-1:0] ra2, ra3;
  logic [2:0] cmd2, cmd3;
  logic en2, busy2, en3, busy3;
  logic [2:0] req3 = '0, ack3, v3, e3;
  logic [3*AW-1:0] addr3 = {27'h0000033, 27'h0000022, 27'h0000011};
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ram_read_arbiter #(.NUM_REQ(2), .ADDR_W(AW), .TIMEOUT_CYC(1023)) u2 (
    .clk(clk), .reset_n(reset_n), .req(req2), .req_addr(addr2), .req_ack(ack2),
    .rsp_valid(v2), .rsp_err(e2), .rsp_data(data2), .ram_address(ra2), .ram_cmd(cmd2),
    .ram_en(en2), .ram_rdy(rdy), .ram_rd_valid(rv), .ram_rd_data_end(rend),
    .ram_rd_data(rdata), .busy(busy2));
  ram_read_arbiter #(.NUM_REQ(3), .ADDR_W(AW), .TIMEOUT_CYC(16)) u3 (
    .clk(clk), .reset_n(reset_n), .req(req3), .req_addr(addr3), .req_ack(ack3),
    .rsp_valid(v3), .rsp_err(e3), .rsp_data(data3), .ram_address(ra3), .ram_cmd(cmd3),
    .ram_en(en3), .ram_rdy(rdy), .ram_rd_valid(rv), .ram_rd_data_end(rend),
    .ram_rd_data(rdata), .busy(busy3));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic beat(input logic [63:0] d, input logic e);
    rv = 1'b1;
    rend = e;
    rdata = d;
    tick;
    rv = 1'b0;
    rend = 1'b0;
  endtask
  task automatic run2(input int g, input logic [63:0] a, input logic [63:0] b);
    logic [1:0] oh;
    logic [AW-1:0] ea;
    oh = 2'b01 << g;
    ea = addr2[g*AW +: AW] & ~AW'(7);
    #1 chk("rr2_ack", ack2, oh);
    tick;
    req2[g] = 1'b0;
    chk("rr2_addr", ra2, ea);
    tick;
    beat(a, 1'b0);
    beat(b, 1'b1);
    chk("rr2_valid", v2, oh);
    chk("rr2_err", e2, 2'b00);
    chk("rr2_data", data2, {b, a});
    req2[g] = 1'b1;
  endtask
  task automatic run3(input int g, input logic [63:0] a, input logic [63:0] b);
    logic [2:0] oh;
    logic [AW-1:0] ea;
    oh = 3'b001 << g;
    ea = addr3[g*AW +: AW] & ~AW'(7);
    #1 chk("rr3_ack", ack3, oh);
    tick;
    req3[g] = 1'b0;
    chk("rr3_addr", ra3, ea);
    tick;
    beat(a, 1'b0);
    beat(b, 1'b1);
    chk("rr3_valid", v3, oh);
    chk("rr3_data", data3, {b, a});
    req3[g] = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, ok;
    tick;
    tick;
    chk("rst_busy", busy2, 1'b0);
    chk("rst_en", en2, 1'b0);
    chk("rst_cmd", cmd2, 3'b000);
    chk("rst_addr", ra2, '0);
    chk("rst_data", data2, '0);
    chk("rst_rsp", {v2, e2, ack2}, '0);
    reset_n = 1'b1;
    tick;
    rdy = 1'b1;
    req2 = 2'b01;
    #1 chk("t1_ack", ack2, 2'b01);
    tick;
    req2 = 2'b00;
    chk("t1_en", en2, 1'b1);
    chk("t1_cmd", cmd2, 3'b001);
    chk("t1_addr", ra2, 27'h1234560);
    chk("t1_busy", busy2, 1'b1);
    tick;
    repeat (3) tick;
    beat(64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
    beat(64'hBBBB_BBBB_BBBB_BBBB, 1'b1);
    chk("t1_valid", v2, 2'b01);
    chk("t1_data", data2, {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});
    tick;
    chk("t1_pulse", v2, 2'b00);
    chk("t1_hold", data2, {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});
    req2 = 2'b11;
    run2(1, 64'hA1, 64'hB1);
    run2(0, 64'hA2, 64'hB2);
    run2(1, 64'hA3, 64'hB3);
    run2(0, 64'hA4, 64'hB4);
    req2 = 2'b00;
    tick;
    rdy = 1'b0;
    req2 = 2'b01;
    #1 chk("t3_ack", ack2, 2'b01);
    tick;
    req2 = 2'b00;
    ok = 0;
    repeat (20) begin
      ok += int'(en2 === 1'b1 && ra2 === 27'h1234560 && e2 === 2'b00);
      tick;
    end
    chk("t3_stall", ok, 20);
    chk("t3_en_hold", en2, 1'b1);
    rdy = 1'b1;
    tick;
    chk("t3_en_drop", en2, 1'b0);
    beat(64'hC0, 1'b0);
    beat(64'hD0, 1'b1);
    chk("t3_valid", {v2, e2}, 4'b0100);
    chk("t3_data", data2, {64'hD0, 64'hC0});
    req2 = 2'b10;
    #1 chk("t4_ack", ack2, 2'b10);
    tick;
    req2 = 2'b00;
    tick;
    n = 0;
    while (e2 == 2'b00 && n < 1100) begin
      tick;
      n++;
    end
    chk("t4_latency", n, 1023);
    chk("t4_err", {e2, v2}, 4'b1000);
    chk("t4_idle", busy2, 1'b0);
    beat(64'hDEAD, 1'b1);
    chk("t4_late", {v2, e2, ack2, busy2}, '0);
    chk("t4_data", data2, {64'hD0, 64'hC0});
    req2 = 2'b01;
    #1 chk("t4b_ack", ack2, 2'b01);
    tick;
    req2 = 2'b00;
    tick;
    beat(64'hEE, 1'b1);
    chk("t4b_err", {e2, v2}, 4'b0100);
    chk("t4b_data", data2, {64'hD0, 64'hC0});
    req2 = 2'b01;
    #1;
    tick;
    req2 = 2'b00;
    tick;
    beat(64'hF0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("t5_busy", busy2, 1'b0);
    chk("t5_outs", {en2, cmd2, ra2, v2, e2, ack2}, '0);
    chk("t5_data", data2, '0);
    tick;
    reset_n = 1'b1;
    tick;
    req2 = 2'b11;
    #1 chk("t5_rr", ack2, 2'b10);
    req2 = 2'b00;
    tick;
    chk("t5_drop", busy2, 1'b0);
    req3 = 3'b111;
    run3(1, 64'h31, 64'h41);
    run3(2, 64'h32, 64'h42);
    run3(0, 64'h33, 64'h43);
    run3(1, 64'h34, 64'h44);
    req3 = 3'b000;
    tick;
    chk("t6_idle2", {v2, e2, busy2}, '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
